// File: rtl/seq_divider_16x8_pkg.sv
// Package div_pkg: shared types and constants for the 16/8 sequential divider.
//   state_t        FSM states of the divider top level
//   *_DEF          default operand widths and approximation depth
//   CNT_W          iteration counter width for the default dividend width
//   DBZ_QUOTIENT   quotient reported when the divisor is zero
package div_pkg;

    localparam int WIDTH_N_DEF    = 16;
    localparam int WIDTH_D_DEF    = 8;
    localparam int APPROX_LSB_DEF = 4;
    localparam int CNT_W          = $clog2(WIDTH_N_DEF);

    localparam logic [WIDTH_N_DEF-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_16x8_if.sv
// Interface seq_divider_16x8_if: operand and result handshakes of the divider.
//   in_valid/in_ready    operand handshake (dividend, divisor)
//   out_valid/out_ready  result handshake (quotient, remainder, div_by_zero)
//   modport slave        divider side
//   modport master       producer/consumer side
interface seq_divider_16x8_if
    import div_pkg::*;
#(
    parameter int WIDTH_N = WIDTH_N_DEF,
    parameter int WIDTH_D = WIDTH_D_DEF
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH_N-1:0] dividend;
    logic [WIDTH_D-1:0] divisor;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH_N-1:0] quotient;
    logic [WIDTH_D-1:0] remainder;
    logic               div_by_zero;

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_16x8_step.sv
// Module div_step: one combinational radix-2 restoring division step.
//   pr       in   current partial remainder (always below divisor)
//   dvd_bit  in   next dividend bit shifted in
//   divisor  in   denominator
//   pr_next  out  partial remainder after this step
//   q_bit    out  resolved quotient bit
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH_D = WIDTH_D_DEF
) (
    input  logic [WIDTH_D-1:0] pr,
    input  logic               dvd_bit,
    input  logic [WIDTH_D-1:0] divisor,
    output logic [WIDTH_D-1:0] pr_next,
    output logic               q_bit
);
    logic [WIDTH_D:0]   pr_shift;
    logic [WIDTH_D-1:0] diff;

    // The partial remainder stays below the divisor, so WIDTH_D bits hold it;
    // only the shifted value needs the extra bit. When the subtraction is
    // taken its result is below the divisor, so a WIDTH_D-bit modular
    // difference is exact.
    assign pr_shift = {pr, dvd_bit};
    assign q_bit    = (pr_shift >= {1'b0, divisor});
    assign diff     = pr_shift[WIDTH_D-1:0] - divisor;
    assign pr_next  = q_bit ? diff : pr_shift[WIDTH_D-1:0];
endmodule

// File: rtl/seq_divider_16x8.sv
// Module seq_divider_16x8: sequential restoring divider, one quotient bit per clock.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of seq_divider_16x8_if (operand and result handshakes)
// Build option DIV_APPROX_EN: stop after WIDTH_N-APPROX_LSB iterations,
// leaving the low APPROX_LSB quotient bits and the remainder at zero.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// RUN   | resolving one quotient bit per clock, MSB first
// DONE  | out_valid=1, result held until out_ready
module seq_divider_16x8
    import div_pkg::*;
#(
    parameter int WIDTH_N    = WIDTH_N_DEF,
    parameter int WIDTH_D    = WIDTH_D_DEF,
    parameter int APPROX_LSB = APPROX_LSB_DEF
) (
    input logic               clk,
    input logic               rst_n,
    seq_divider_16x8_if.slave bus
);
    localparam int LCNT_W = $clog2(WIDTH_N);

`ifdef DIV_APPROX_EN
    localparam logic [LCNT_W-1:0] LAST_CNT = LCNT_W'(APPROX_LSB);
`else
    localparam logic [LCNT_W-1:0] LAST_CNT = '0;
`endif

    state_t             state, state_nxt;
    logic [LCNT_W-1:0]  cnt;
    logic [WIDTH_N-1:0] dvd_q;
    logic [WIDTH_D-1:0] dsr_q;
    logic [WIDTH_D-1:0] pr_q;
    logic [WIDTH_D-1:0] pr_nxt;
    logic [WIDTH_N-1:0] q_q;
    logic [WIDTH_D-1:0] rem_q;
    logic               dbz_q;
    logic               q_bit;
    logic               accept;
    logic               last_step;

    div_step #(.WIDTH_D(WIDTH_D)) u_step (
        .pr      (pr_q),
        .dvd_bit (dvd_q[cnt]),
        .divisor (dsr_q),
        .pr_next (pr_nxt),
        .q_bit   (q_bit)
    );

    assign accept    = bus.in_valid && (state == IDLE);
    assign last_step = (state == RUN) && (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = (bus.divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                if (cnt == LAST_CNT) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            dvd_q <= '0;
            dsr_q <= '0;
            pr_q  <= '0;
            q_q   <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            dvd_q <= bus.dividend;
            dsr_q <= bus.divisor;
            pr_q  <= '0;
            cnt   <= LCNT_W'(WIDTH_N - 1);
            dbz_q <= (bus.divisor == '0);
            if (bus.divisor == '0) begin
                q_q   <= DBZ_QUOTIENT;
                rem_q <= bus.dividend[WIDTH_D-1:0];
            end else begin
                q_q   <= '0;
                rem_q <= '0;
            end
        end else if (state == RUN) begin
            pr_q     <= pr_nxt;
            q_q[cnt] <= q_bit;
            if (last_step) begin
`ifdef DIV_APPROX_EN
                rem_q <= '0;
`else
                rem_q <= pr_nxt;
`endif
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign bus.quotient    = q_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_16x8.sv
// Testbench tb_seq_divider_16x8: directed vectors for seq_divider_16x8.
// Expectations follow DIV_APPROX_EN when it is defined for the build.
module tb_seq_divider_16x8;
    import div_pkg::*;

`ifdef DIV_APPROX_EN
    localparam int          LAT   = 13;
    localparam logic [15:0] QMASK = 16'hFFF0;
    localparam logic [7:0]  RMASK = 8'h00;
`else
    localparam int          LAT   = 17;
    localparam logic [15:0] QMASK = 16'hFFFF;
    localparam logic [7:0]  RMASK = 8'hFF;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    seq_divider_16x8_if bus ();

    seq_divider_16x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = 16'hA5A5;
        bus.divisor  = 8'h3C;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid_seen", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic handshake;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("out_valid_dropped", 32'(bus.out_valid), 32'd0);
        chk("in_ready_back", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                           input logic [15:0] eq, input logic [7:0] er,
                           input logic edbz, input int elat);
        int lat;
        issue(a, b);
        if (b != 8'd0) begin
            chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
            chk({tag, "_dbz_clear"}, 32'(bus.div_by_zero), 32'd0);
        end
        wait_result(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
        chk({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edbz));
        handshake();
    endtask

    initial begin
        logic [15:0] hq;
        logic [7:0]  hr;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_quotient", 32'(bus.quotient), 32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_div("d200_7", 16'd200, 8'd7, 16'd28 & QMASK, 8'd4 & RMASK, 1'b0, LAT);
        run_div("d65535_1", 16'd65535, 8'd1, 16'd65535 & QMASK, 8'd0, 1'b0, LAT);
        run_div("d65535_255", 16'd65535, 8'd255, 16'd257 & QMASK, 8'd0, 1'b0, LAT);
        run_div("d1234_0", 16'd1234, 8'd0, 16'hFFFF, 8'hD2, 1'b1, 1);

        // Result held while the consumer stalls; producer noise must be ignored.
        begin
            int lat;
            issue(16'd5, 8'd9);
            chk("d5_9_dbz_clear", 32'(bus.div_by_zero), 32'd0);
            wait_result(lat);
            chk("d5_9_latency", 32'(lat), 32'(LAT));
            chk("d5_9_quotient", 32'(bus.quotient), 32'd0);
            chk("d5_9_remainder", 32'(bus.remainder), 32'(8'd5 & RMASK));
            hq = bus.quotient;
            hr = bus.remainder;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                bus.in_valid = i[0];
                bus.dividend = 16'($urandom);
                bus.divisor  = 8'($urandom);
                @(posedge clk);
                #1;
                chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
                chk("hold_quotient", 32'(bus.quotient), 32'(hq));
                chk("hold_remainder", 32'(bus.remainder), 32'(hr));
            end
            bus.in_valid = 1'b0;
            handshake();
        end

        // Reset in the middle of RUN aborts the division.
        issue(16'd40000, 8'd3);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_quotient", 32'(bus.quotient), 32'd0);
        chk("abort_remainder", 32'(bus.remainder), 32'd0);
        chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_result", 32'(bus.out_valid), 32'd0);
        run_div("d40000_3", 16'd40000, 8'd3, 16'd13333 & QMASK, 8'd1 & RMASK, 1'b0, LAT);

        // Random sweep against a behavioural division.
        for (int k = 0; k < 20; k++) begin
            logic [15:0] a;
            logic [7:0]  b;
            logic [15:0] eq;
            logic [7:0]  er;
            int          lat;
            a  = 16'($urandom_range(0, 65535));
            b  = 8'($urandom_range(1, 255));
            eq = a / 16'(b);
            er = 8'(a % 16'(b));
            issue(a, b);
            wait_result(lat);
            chk("rnd_latency", 32'(lat), 32'(LAT));
`ifdef DIV_APPROX_EN
            chk("rnd_q_le_exact", 32'(bus.quotient <= eq), 32'd1);
            chk("rnd_err_lt16", 32'((eq - bus.quotient) < 16'd16), 32'd1);
            chk("rnd_q_lsb_zero", 32'(bus.quotient[3:0]), 32'd0);
            chk("rnd_remainder", 32'(bus.remainder), 32'd0);
`else
            chk("rnd_quotient", 32'(bus.quotient), 32'(eq));
            chk("rnd_remainder", 32'(bus.remainder), 32'(er));
`endif
            handshake();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
